// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the scoreboarded register file: address-width helper,
// flat-vector slice helper and the hard-wired zero register index.
package regfile_pkg;

    localparam int unsigned ZERO_REG = 0;

    function automatic int addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Low bit of field k in a flat vector of w-bit fields
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/reg_file_sb_rdport.sv
// One read port: zero-register masking, same-cycle write bypass with
// highest-port priority, and the per-port busy flag.
module reg_file_sb_rdport
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]       raddr,
    input  logic [XLEN-1:0]     stored,
    input  logic                busy_bit,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    output logic [XLEN-1:0]     rdata,
    output logic                rbusy
);

    logic            hit;
    logic [XLEN-1:0] fwd;

    // Ascending scan so the highest-numbered matching port is the one kept
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        for (int k = 0; k < NWR; k++) begin
            if (we[k] && (waddr[slice_lo(k, AW) +: AW] == raddr)) begin
                hit = 1'b1;
                fwd = wdata[slice_lo(k, XLEN) +: XLEN];
            end
        end
    end

    always_comb begin
        rdata = stored;
        rbusy = busy_bit;
        if (raddr == AW'(ZERO_REG)) begin
            rdata = '0;
            rbusy = 1'b0;
        end else if ((BYPASS != 0) && hit) begin
            rdata = fwd;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port GPR file for the ID stage with per-register busy scoreboard:
// destinations are reserved at issue and released by writeback.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = addr_w(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic [NREGS-1:0]    busy
);

    logic [XLEN-1:0]  regs [1:NREGS-1];
    logic [XLEN-1:0]  rf_view [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NWR-1:0]   we_eff;

    // Write and issue ports have no valid/ready pair: every asserted we[k] or
    // issue_valid is accepted in the cycle it is presented, except under reset.
    assign we_eff = rst ? '0 : we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we_eff[k] && (waddr[slice_lo(k, AW) +: AW] != AW'(ZERO_REG)))
                    regs[waddr[slice_lo(k, AW) +: AW]] <= wdata[slice_lo(k, XLEN) +: XLEN];
            end
        end
    end

    // Set after clear: a new reservation outlives a same-cycle writeback
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (we_eff[k]) busy_d[waddr[slice_lo(k, AW) +: AW]] = 1'b0;
        end
        if (issue_valid) busy_d[issue_rd] = 1'b1;
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy = busy_q;

    always_comb begin
        rf_view[0] = '0;
        for (int r = 1; r < NREGS; r++) rf_view[r] = regs[r];
    end

    for (genvar i = 0; i < NRD; i++) begin : gen_rd
        logic [AW-1:0] ra;
        assign ra = raddr[i*AW +: AW];

        reg_file_sb_rdport #(
            .XLEN  (XLEN),
            .AW    (AW),
            .NWR   (NWR),
            .BYPASS(BYPASS)
        ) u_rdport (
            .raddr   (ra),
            .stored  (rf_view[ra]),
            .busy_bit(busy_q[ra]),
            .we      (we_eff),
            .waddr   (waddr),
            .wdata   (wdata),
            .rdata   (rdata[i*XLEN +: XLEN]),
            .rbusy   (rbusy[i])
        );
    end

    for (genvar r = 0; r < NREGS; r++) begin : gen_dbg
        logic [XLEN-1:0] value;
        logic            is_busy;
        assign value   = rf_view[r];
        assign is_busy = busy_q[r];
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one bypassing two-write-port instance and one
// non-bypassing single-write-port instance driven from shared stimulus.
module tb_reg_file_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk;
    logic            rst;
    logic [1:0]      we;
    logic [2*AW-1:0] waddr;
    logic [63:0]     wdata;
    logic [2*AW-1:0] raddr;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;

    logic [63:0]      rdata;
    logic [1:0]       rbusy;
    logic [NREGS-1:0] busy;
    logic [63:0]      nb_rdata;
    logic [1:0]       nb_rbusy;
    logic [NREGS-1:0] nb_busy;

    int n_checks = 0;
    int n_errors = 0;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy)
    );

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we(we[0:0]), .waddr(waddr[AW-1:0]),
        .wdata(wdata[XLEN-1:0]), .raddr(raddr), .rdata(nb_rdata),
        .rbusy(nb_rbusy), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy(nb_busy)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we          = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    task automatic drv_wr(input int port, input int addr, input logic [31:0] data);
        we[port]               = 1'b1;
        waddr[port*AW +: AW]   = AW'(addr);
        wdata[port*XLEN +: XLEN] = data;
    endtask

    task automatic drv_rd(input int port, input int addr);
        raddr[port*AW +: AW] = AW'(addr);
    endtask

    task automatic drv_issue(input int rd);
        issue_valid = 1'b1;
        issue_rd    = AW'(rd);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        raddr = '0;
        waddr = '0;
        wdata = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Every address reads 0 / not busy while reset is held
        for (int a = 0; a < NREGS; a++) begin
            drv_rd(0, a);
            drv_rd(1, NREGS - 1 - a);
            #1;
            chk($sformatf("rst_rdata_a%0d", a), rdata, 64'h0);
            chk($sformatf("rst_rbusy_a%0d", a), {62'h0, rbusy}, 64'h0);
        end
        chk("rst_busy", {32'h0, busy}, 64'h0);
        chk("rst_nb_busy", {32'h0, nb_busy}, 64'h0);
        tick();
        rst = 1'b0;

        // Write 5 with same-cycle read: bypass vs. stored value
        drv_wr(0, 5, 32'hDEADBEEF);
        drv_rd(0, 5);
        drv_rd(1, 5);
        #1;
        chk("byp_rdata0", {32'h0, rdata[31:0]}, 64'hDEADBEEF);
        chk("byp_rdata1", {32'h0, rdata[63:32]}, 64'hDEADBEEF);
        chk("nobyp_old", {32'h0, nb_rdata[31:0]}, 64'h0);
        tick();
        idle();
        #1;
        chk("byp_stored", {32'h0, rdata[31:0]}, 64'hDEADBEEF);
        chk("nobyp_next", {32'h0, nb_rdata[31:0]}, 64'hDEADBEEF);
        chk("wr_nonbusy_busy", {32'h0, busy}, 64'h0);

        // Register 0: write ignored, issue ignored
        drv_wr(0, 0, 32'h1234);
        drv_issue(0);
        drv_rd(0, 0);
        #1;
        chk("r0_byp", {32'h0, rdata[31:0]}, 64'h0);
        tick();
        idle();
        #1;
        chk("r0_stored", {32'h0, rdata[31:0]}, 64'h0);
        chk("r0_busy", {32'h0, busy}, 64'h0);

        // Issue 7 at N, writeback at N+3
        drv_issue(7);
        drv_rd(0, 7);
        #1;
        chk("iss7_not_yet", {63'h0, rbusy[0]}, 64'h0);
        tick();
        idle();
        #1;
        chk("iss7_busy", {32'h0, busy}, 64'h80);
        chk("iss7_rbusy", {63'h0, rbusy[0]}, 64'h1);
        chk("iss7_nb_rbusy", {63'h0, nb_rbusy[0]}, 64'h1);
        tick();
        tick();
        drv_wr(0, 7, 32'h0000_0077);
        #1;
        chk("wb7_rbusy_byp", {63'h0, rbusy[0]}, 64'h0);
        chk("wb7_rdata_byp", {32'h0, rdata[31:0]}, 64'h77);
        chk("wb7_nb_rbusy", {63'h0, nb_rbusy[0]}, 64'h1);
        chk("wb7_nb_rdata", {32'h0, nb_rdata[31:0]}, 64'h0);
        tick();
        idle();
        #1;
        chk("wb7_busy_clr", {32'h0, busy}, 64'h0);
        chk("wb7_rdata", {32'h0, rdata[31:0]}, 64'h77);
        chk("wb7_nb_rdata2", {32'h0, nb_rdata[31:0]}, 64'h77);

        // Same-cycle issue and writeback of busy register 9
        drv_issue(9);
        tick();
        idle();
        #1;
        chk("iss9_busy", {32'h0, busy}, 64'h200);
        drv_issue(9);
        drv_wr(0, 9, 32'h0000_0099);
        drv_rd(0, 9);
        tick();
        idle();
        #1;
        chk("iss9_set_wins", {32'h0, busy}, 64'h200);
        chk("iss9_rbusy", {63'h0, rbusy[0]}, 64'h1);
        chk("iss9_rdata", {32'h0, rdata[31:0]}, 64'h99);
        drv_wr(0, 9, 32'h0000_009A);
        tick();
        idle();
        #1;
        chk("wb9_busy_clr", {32'h0, busy}, 64'h0);

        // Both write ports hit register 3: port 1 wins
        drv_wr(0, 3, 32'h0000_000A);
        drv_wr(1, 3, 32'h0000_000B);
        drv_rd(0, 3);
        #1;
        chk("dual3_byp", {32'h0, rdata[31:0]}, 64'hB);
        chk("dual3_nb_old", {32'h0, nb_rdata[31:0]}, 64'h0);
        tick();
        idle();
        #1;
        chk("dual3_stored", {32'h0, rdata[31:0]}, 64'hB);
        chk("dual3_nb_port0", {32'h0, nb_rdata[31:0]}, 64'hA);

        // Port 1 alone, read port 1
        drv_wr(1, 12, 32'h0000_000C);
        drv_rd(1, 12);
        #1;
        chk("p1_byp", {32'h0, rdata[63:32]}, 64'hC);
        tick();
        idle();
        #1;
        chk("p1_stored", {32'h0, rdata[63:32]}, 64'hC);

        // Reservation outstanding, then asynchronous reset mid-cycle
        drv_issue(4);
        tick();
        idle();
        #1;
        chk("iss4_busy", {32'h0, busy}, 64'h10);
        drv_wr(0, 5, 32'h0000_0055);
        drv_rd(0, 5);
        drv_rd(1, 3);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_rdata", rdata, 64'h0);
        chk("arst_busy", {32'h0, busy}, 64'h0);
        chk("arst_rbusy", {62'h0, rbusy}, 64'h0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("post_rst_rdata", rdata, 64'h0);
        chk("post_rst_nb_rdata", nb_rdata, 64'h0);
        chk("post_rst_busy", {32'h0, busy}, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
